// File: rtl/gate_arpeggiator_pkg.sv
// Shared constants and duration helpers for the gate arpeggiator and its trigger debouncer.
package gate_arpeggiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE_ON,
    ST_GATE_OFF
  } state_e;

  localparam int unsigned DEBOUNCE_DEFAULT = 5000;
  localparam logic [15:0] MIN_STEP_TICKS   = 16'd2;
  localparam logic [15:0] MIN_GATE_TICKS   = 16'd1;

  function automatic logic [15:0] eff_step_len(input logic [15:0] ticks);
    return (ticks < MIN_STEP_TICKS) ? MIN_STEP_TICKS : ticks;
  endfunction

  // Gate is kept strictly shorter than the step so every step ends with a low cycle.
  function automatic logic [15:0] eff_gate_len(input logic [15:0] ticks,
                                               input logic [15:0] step_len);
    if (ticks < MIN_GATE_TICKS) return MIN_GATE_TICKS;
    if (ticks >= step_len) return step_len - 16'd1;
    return ticks;
  endfunction

endpackage

// File: rtl/gate_arpeggiator_if.sv
// Arpeggio control inputs and voice-facing outputs of the gate arpeggiator.
interface gate_arpeggiator_if;
  logic [15:0] tone_a;
  logic [15:0] tone_b;
  logic [15:0] tone_c;
  logic [15:0] step_ticks;
  logic [15:0] gate_ticks;
  logic [15:0] tone_freq;
  logic        gate;
  logic [1:0]  step_idx;
  logic        busy;

  modport master (
    output tone_a, tone_b, tone_c, step_ticks, gate_ticks,
    input  tone_freq, gate, step_idx, busy
  );

  modport slave (
    input  tone_a, tone_b, tone_c, step_ticks, gate_ticks,
    output tone_freq, gate, step_idx, busy
  );
endinterface

// File: rtl/gate_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for an asynchronous control pin.
module gate_debouncer
  import gate_arpeggiator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync_q;
  logic        level_q;
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], din};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST_COUNT) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign dout = level_q;

endmodule

// File: rtl/gate_arpeggiator.sv
// Debounced push-button arpeggiator: steps three tone words with a retriggering gate while held.
module gate_arpeggiator
  import gate_arpeggiator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trig_n,
  gate_arpeggiator_if.slave    voice
);

  logic trig_level;
  logic pressed;

  gate_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (trig_n),
    .dout (trig_level)
  );

  assign pressed = ~trig_level;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] step_len_q;
  logic [15:0] gate_len_q;
  logic [15:0] tone_q;
  logic [1:0]  step_q;
  logic        gate_q;
  logic        busy_q;

  logic [1:0]  step_d;
  logic [15:0] tone_d;
  logic [15:0] step_len_d;
  logic [15:0] gate_len_d;
  logic [15:0] off_len;

  always_comb begin
    step_d = (state_q == ST_IDLE || step_q == 2'd2) ? 2'd0 : step_q + 2'd1;
    case (step_d)
      2'd0:    tone_d = voice.tone_a;
      2'd1:    tone_d = voice.tone_b;
      default: tone_d = voice.tone_c;
    endcase
    step_len_d = eff_step_len(voice.step_ticks);
    gate_len_d = eff_gate_len(voice.gate_ticks, step_len_d);
  end

  assign off_len = step_len_q - gate_len_q;

  // Release is tested first so it overrides a coinciding step boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      step_len_q <= '0;
      gate_len_q <= '0;
      tone_q     <= '0;
      step_q     <= '0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else if (state_q != ST_IDLE && !pressed) begin
      state_q <= ST_IDLE;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= '0;
      cnt_q   <= '0;
    end else if ((state_q == ST_IDLE && pressed) ||
                 (state_q == ST_GATE_OFF && cnt_q == off_len)) begin
      state_q    <= ST_GATE_ON;
      step_q     <= step_d;
      tone_q     <= tone_d;
      step_len_q <= step_len_d;
      gate_len_q <= gate_len_d;
      gate_q     <= 1'b1;
      busy_q     <= 1'b1;
      cnt_q      <= 16'd1;
    end else if (state_q == ST_GATE_ON && cnt_q == gate_len_q) begin
      state_q <= ST_GATE_OFF;
      gate_q  <= 1'b0;
      cnt_q   <= 16'd1;
    end else if (state_q != ST_IDLE) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign voice.tone_freq = tone_q;
  assign voice.gate      = gate_q;
  assign voice.step_idx  = step_q;
  assign voice.busy      = busy_q;

endmodule

// File: doc/gate_arpeggiator.md
# gate_arpeggiator

Upstream control stage for the voice bank: conditions a raw active-low push-button/gate pin (synchroniser plus debouncer) and, while it is held, steps through a three-note arpeggio. For each note it drives `tone_freq` and a retriggering `gate` into a single `voice`. It runs in the 1 MHz tone-generator clock domain. Releasing the pin drops `gate` and holds the last pitch so the envelope release tail stays on that note.

## Interface
- `DEBOUNCE_CYCLES`, default 5000: consecutive stable synchronised samples required to accept a trigger level change (5 ms at 1 MHz); legal range 1..65535.
- `clk`, in, 1: tone-domain clock (1 MHz); all logic on the rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `trig_n`, in, 1: raw pin; asynchronous; low = pressed.
- `tone_a`, `tone_b`, `tone_c`, in, 16 each: `tone_freq` words for steps 0, 1 and 2.
- `step_ticks`, in, 16: clocks per arpeggio step.
- `gate_ticks`, in, 16: clocks `gate` is high at the start of each step.
- `tone_freq`, out, 16: to `voice.tone_freq`.
- `gate`, out, 1: to `voice.gate`.
- `step_idx`, out, 2: current step, 0..2.
- `busy`, out, 1: arpeggio running (debounced trigger pressed).

## Operation
- Reset values: `tone_freq`=0, `gate`=0, `step_idx`=0, `busy`=0. The synchroniser resets to 1 (released), the debounced level resets to released, and the FSM resets to IDLE.
- Synchroniser: two flops on `trig_n`.
- Debouncer:
  - Counter clears whenever the synchronised value equals the debounced level.
  - Otherwise the counter increments; on reaching `DEBOUNCE_CYCLES` the debounced level takes the synchronised value and the counter clears.
  - Any bounce back to the old level clears the counter.
- Effective durations are computed at step start and latched with the tone word:
  - S = max(`step_ticks`, 2).
  - G = clamp(`gate_ticks`, 1, S-1).
  - Every step therefore has at least 1 gate-high cycle and at least 1 gate-low cycle, which guarantees an ADSR retrigger edge.
- FSM states IDLE, GATE_ON, GATE_OFF:
  - IDLE → GATE_ON on a debounced press. Step 0 starts: latch `tone_a` and S, G; `gate`=1; `busy`=1.
  - GATE_ON → GATE_OFF after G cycles; `gate`=0.
  - GATE_OFF → GATE_ON after S-G cycles. `step_idx` advances 0→1→2→0 (wraps after 2), the next tone is latched, and `gate`=1.
  - Any state → IDLE on a debounced release, effective the next cycle: `gate`=0, `busy`=0, `tone_freq` holds its last value, and `step_idx` resets to 0.
- Tone and duration inputs are sampled only at step start. Mid-step changes affect the next step only.
- A re-press always restarts at step 0 with `tone_a`.
- If release and step boundary coincide, release wins: no new step is latched.

## Timing
- Pin-to-`busy` latency: 2 synchroniser cycles, plus `DEBOUNCE_CYCLES` stable cycles, plus 1 FSM cycle.
- Outputs are registered. `gate`, `tone_freq` and `step_idx` change on the same edge at step start.
- Gate period is exactly S cycles; gate high is exactly G cycles.
- Asserting `rst_n` mid-step forces reset values immediately (asynchronously). Operation resumes from IDLE on the first edge after deassertion. A held pin is re-accepted only after a full debounce.

## Structure
- Constants go in a shared tiny-synth header:
  - FSM state encodings.
  - The default debounce count.
  - Minimum step and gate lengths (2 and 1).
- Sub-module `gate_debouncer`: synchroniser and debounce counter with parameter `DEBOUNCE_CYCLES`, inputs `clk`, `rst_n`, `din`, output `dout` (debounced level). It is reusable for other control pins.
- The top level contains the duration clamp, step/gate counters, tone mux and FSM.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Debounce:** `trig_n` low for 3 cycles then high → `busy` stays 0. Held low 10 cycles → `busy`=1 exactly 2+4+1 cycles after the first low sample.
- **Arpeggio:** `tone_a/b/c`=4389/5530/6577, `step_ticks`=10, `gate_ticks`=4, held 35 cycles. Required:
  - `tone_freq` sequence 4389, 5530, 6577, 4389.
  - `gate` high 4 cycles and low 6 cycles each step.
  - `step_idx` 0, 1, 2, 0.
- **Clamp:** `step_ticks`=0, `gate_ticks`=0 → period 2, gate 1 high/1 low. `step_ticks`=8, `gate_ticks`=20 → gate 7 high/1 low.
- **Release mid-gate:** release during step 1 GATE_ON → `gate`=0 and `busy`=0 one cycle after debounce; `tone_freq` stays 5530. Re-press → restarts with 4389 and `step_idx`=0.
- **Mid-step input change:** change `tone_b` while step 0 is running → step 1 uses the new value. Change `tone_a` during step 1 → no `tone_freq` change until the next step 0.
- **Async reset:** assert `rst_n`=0 mid-GATE_ON → all outputs go to reset values with no clock edge required. After release, a held pin re-arms after 2+4+1 cycles.
